clock_s_multi: RTL and testbench

//  Multi-channel seconds alarm timer: CH independent channels, each counting
//  a programmed number of seconds from a shared Clk and pulsing on expiry.

---
 rtl/clock_s_multi.sv | 168 ++++++++++++++++
 tb/tb_clock_s_multi.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_s_multi.sv
// clock_s_multi: multi-channel seconds alarm timer.
// Each of CH channels counts a programmed number of seconds (TICK_DIV Clk
// cycles each) and emits a one-cycle registered pulse on expiry. Channels
// support one-shot or auto-reload mode, abort (stop) and restart (start).
// Optional feature macro: CLOCK_S_IRQ_EN adds sticky per-channel interrupt
// flags (irq) with per-channel clear strobes (irq_clr).
module clock_s_multi #(
    parameter int CH       = 4,
    parameter int AW       = 8,
    parameter int TICK_DIV = 32768
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [CH-1:0]    start,
    input  logic [CH-1:0]    stop,
    input  logic [CH-1:0]    periodic,
    input  logic [CH*AW-1:0] alarm,
    output logic [CH-1:0]    pulse,
    output logic [CH-1:0]    busy,
    output logic [CH*AW-1:0] sec_left
`ifdef CLOCK_S_IRQ_EN
    ,
    input  logic [CH-1:0]    irq_clr,
    output logic [CH-1:0]    irq
`endif
);

    // Sub-second counter width and its terminal value.
    localparam int SW = $clog2(TICK_DIV);
    localparam logic [SW-1:0] SUB_MAX = SW'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [AW-1:0] r_sec;
        logic [AW-1:0] w_sec_nxt;
        logic [AW-1:0] r_alarm;
        logic [AW-1:0] w_alarm_nxt;
        logic [SW-1:0] r_sub;
        logic [SW-1:0] w_sub_nxt;
        logic          r_per;
        logic          w_per_nxt;
        logic          r_pulse;
        logic          w_pulse_nxt;
        logic [AW-1:0] w_alarm_in;
        logic          w_alarm_nz;
        logic          w_wrap;

        assign w_alarm_in = alarm[g*AW +: AW];
        assign w_alarm_nz = (w_alarm_in != {AW{1'b0}});
        assign w_wrap     = (r_sub == SUB_MAX);

        // Channel state register: FSM state, counters, latched config, pulse.
        always_ff @(posedge Clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_sec   <= {AW{1'b0}};
                r_alarm <= {AW{1'b0}};
                r_sub   <= {SW{1'b0}};
                r_per   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_sec   <= w_sec_nxt;
                r_alarm <= w_alarm_nxt;
                r_sub   <= w_sub_nxt;
                r_per   <= w_per_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Next-state logic: stop beats start, start beats expiry.
        always_comb begin
            w_state_nxt = r_state;
            w_sec_nxt   = r_sec;
            w_alarm_nxt = r_alarm;
            w_sub_nxt   = r_sub;
            w_per_nxt   = r_per;
            w_pulse_nxt = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (stop[g]) begin
                        // Abort while idle (even with start) leaves it idle.
                        w_state_nxt = ST_IDLE;
                    end else if (start[g] && w_alarm_nz) begin
                        w_state_nxt = ST_RUN;
                        w_sec_nxt   = w_alarm_in;
                        w_alarm_nxt = w_alarm_in;
                        w_per_nxt   = periodic[g];
                        w_sub_nxt   = {SW{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop[g]) begin
                        w_state_nxt = ST_IDLE;
                        w_sec_nxt   = {AW{1'b0}};
                        w_sub_nxt   = {SW{1'b0}};
                    end else if (start[g]) begin
                        w_alarm_nxt = w_alarm_in;
                        w_per_nxt   = periodic[g];
                        w_sub_nxt   = {SW{1'b0}};
                        if (w_alarm_nz) begin
                            w_state_nxt = ST_RUN;
                            w_sec_nxt   = w_alarm_in;
                        end else begin
                            // Restart with zero seconds cancels the channel.
                            w_state_nxt = ST_IDLE;
                            w_sec_nxt   = {AW{1'b0}};
                        end
                    end else if (w_wrap) begin
                        w_sub_nxt = {SW{1'b0}};
                        if (r_sec == AW'(1)) begin
                            w_pulse_nxt = 1'b1;
                            if (r_per) begin
                                w_state_nxt = ST_RUN;
                                w_sec_nxt   = r_alarm;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_sec_nxt   = {AW{1'b0}};
                            end
                        end else begin
                            // r_sec >= 2 here, so no underflow.
                            w_sec_nxt = r_sec - AW'(1);
                        end
                    end else begin
                        w_sub_nxt = r_sub + SW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sec_nxt   = {AW{1'b0}};
                    w_sub_nxt   = {SW{1'b0}};
                end
            endcase
        end

        assign pulse[g]             = r_pulse;
        assign busy[g]              = (r_state == ST_RUN);
        assign sec_left[g*AW +: AW] = r_sec;

`ifdef CLOCK_S_IRQ_EN
        logic r_irq;

        // Sticky interrupt flag: set with the pulse, cleared by irq_clr; set wins.
        always_ff @(posedge Clk) begin
            if (rst) begin
                r_irq <= 1'b0;
            end else if (w_pulse_nxt) begin
                r_irq <= 1'b1;
            end else if (irq_clr[g]) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_irq;
            end
        end

        assign irq[g] = r_irq;
`endif
    end

endmodule

// File: tb/tb_clock_s_multi.sv
// tb_clock_s_multi: randomized + directed bench for clock_s_multi with a
// deadline-based reference model (expiry time = start cycle + alarm*TICK_DIV).
module tb_clock_s_multi;

    localparam int CH = 4;
    localparam int AW = 8;
    localparam int T  = 4;

    logic             Clk;
    logic             rst;
    logic [CH-1:0]    start;
    logic [CH-1:0]    stop;
    logic [CH-1:0]    periodic;
    logic [CH*AW-1:0] alarm;
    logic [CH-1:0]    pulse;
    logic [CH-1:0]    busy;
    logic [CH*AW-1:0] sec_left;
`ifdef CLOCK_S_IRQ_EN
    logic [CH-1:0]    irq_clr;
    logic [CH-1:0]    irq;
`endif

    clock_s_multi #(.CH(CH), .AW(AW), .TICK_DIV(T)) dut (
        .Clk      (Clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .alarm    (alarm),
        .pulse    (pulse),
        .busy     (busy),
        .sec_left (sec_left)
`ifdef CLOCK_S_IRQ_EN
        ,
        .irq_clr  (irq_clr),
        .irq      (irq)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per channel an active flag and absolute expiry cycle.
    int n = 0;
    bit m_act   [CH];
    int m_next  [CH];
    int m_alarm [CH];
    bit m_per   [CH];
    bit m_pulse [CH];
    bit m_irq   [CH];

    function automatic logic [CH-1:0] exp_pulse();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_pulse[i];
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] v;
        for (int i = 0; i < CH; i++) v[i] = m_act[i];
        return v;
    endfunction

    // Whole seconds remaining = ceil(cycles to expiry / T).
    function automatic logic [CH*AW-1:0] exp_sec();
        logic [CH*AW-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++)
            if (m_act[i]) v[i*AW +: AW] = AW'((m_next[i] - n + T - 1) / T);
        return v;
    endfunction

    // One clock edge: update the model from the sampled inputs, then drop strobes.
    task automatic tick();
        int a;
        @(posedge Clk);
        n++;
        for (int i = 0; i < CH; i++) begin
            m_pulse[i] = 1'b0;
            a = int'(alarm[i*AW +: AW]);
            if (rst) begin
                m_act[i] = 1'b0;
                m_irq[i] = 1'b0;
            end else begin
                if (stop[i]) begin
                    m_act[i] = 1'b0;
                end else if (start[i]) begin
                    if (a != 0) begin
                        m_act[i]   = 1'b1;
                        m_next[i]  = n + a * T;
                        m_alarm[i] = a;
                        m_per[i]   = periodic[i];
                    end else begin
                        m_act[i] = 1'b0;
                    end
                end else if (m_act[i] && n == m_next[i]) begin
                    m_pulse[i] = 1'b1;
                    if (m_per[i]) m_next[i] = n + m_alarm[i] * T;
                    else          m_act[i]  = 1'b0;
                end
`ifdef CLOCK_S_IRQ_EN
                if (m_pulse[i])      m_irq[i] = 1'b1;
                else if (irq_clr[i]) m_irq[i] = 1'b0;
`endif
            end
        end
        #1;
        start = '0;
        stop  = '0;
        rst   = 1'b0;
`ifdef CLOCK_S_IRQ_EN
        irq_clr = '0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (pulse !== 4'h0 || busy !== 4'h0 || sec_left !== 32'h0) begin
            n_bad++;
            $display("FAIL reset: pulse=%b busy=%b sec=%h required all zero", pulse, busy, sec_left);
        end
    endtask

    task automatic test_oneshot();
        int pcyc = -1;
        int pcnt = 0;
        alarm[0*AW +: AW] = 8'd5;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        tick();
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (pulse[0]) begin pcnt++; pcyc = k; end
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL oneshot k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
        end
        n_cmp++;
        if (pcnt != 1 || pcyc != 20) begin
            n_bad++;
            $display("FAIL oneshot_latency: %0d pulses last at +%0d, required 1 at +20", pcnt, pcyc);
        end
    endtask

    task automatic test_periodic();
        int pcnt = 0;
        alarm[1*AW +: AW] = 8'd3;
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (k == 30) stop[1] = 1'b1;
            tick();
            if (pulse[1]) pcnt++;
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL periodic k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
        end
        periodic[1] = 1'b0;
        n_cmp++;
        if (pcnt != 2) begin
            n_bad++;
            $display("FAIL periodic_count: %0d pulses, required 2", pcnt);
        end
    endtask

    task automatic test_zero_restart();
        int pcnt = 0;
        alarm[2*AW +: AW] = 8'd0;
        start[2] = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin alarm[2*AW +: AW] = 8'd2; start[2] = 1'b1; end
            if (k == 9) begin alarm[2*AW +: AW] = 8'd4; start[2] = 1'b1; end
            tick();
            if (pulse[2]) pcnt++;
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL zero_restart k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
            if (k == 25) begin
                n_cmp++;
                if (pulse[2] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL restart_pulse: pulse[2]=%b at +25, required 1", pulse[2]);
                end
            end
        end
        n_cmp++;
        if (pcnt != 1) begin
            n_bad++;
            $display("FAIL restart_count: %0d pulses, required 1", pcnt);
        end
    endtask

    task automatic test_simultaneous();
        alarm = {8'd2, 8'd1, 8'd2, 8'd1};
        periodic = '0;
        start = 4'hF;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL simultaneous k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
            if (k == 4 || k == 8) begin
                n_cmp++;
                if (pulse !== ((k == 4) ? 4'b0101 : 4'b1010)) begin
                    n_bad++;
                    $display("FAIL simultaneous_pulse k=%0d: pulse=%b", k, pulse);
                end
            end
        end
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_cmp++;
            if (pulse[3] !== 1'b0 || busy[3] !== 1'b0) begin
                n_bad++;
                $display("FAIL start_stop k=%0d: pulse3=%b busy3=%b required 0 0", k, pulse[3], busy[3]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int pcnt = 0;
        alarm[0*AW +: AW] = 8'd5;
        start[0] = 1'b1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) rst = 1'b1;
            tick();
            if (pulse != 4'h0) pcnt++;
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL mid_reset k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
        end
        n_cmp++;
        if (pcnt != 0) begin
            n_bad++;
            $display("FAIL mid_reset_pulse: %0d pulses after reset, required 0", pcnt);
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) begin
                r = $urandom_range(0, 63);
                if (r < 3) begin
                    start[i] = 1'b1;
                    alarm[i*AW +: AW] = AW'($urandom_range(0, 5));
                    periodic[i] = 1'($urandom_range(0, 1));
                end
                if (r == 1 || r == 63) stop[i] = 1'b1;
            end
            tick();
            n_cmp++;
            if ({pulse, busy, sec_left} !== {exp_pulse(), exp_busy(), exp_sec()}) begin
                n_bad++;
                $display("FAIL random k=%0d: pulse=%b busy=%b sec=%h required %b %b %h",
                         k, pulse, busy, sec_left, exp_pulse(), exp_busy(), exp_sec());
            end
        end
    endtask

`ifdef CLOCK_S_IRQ_EN
    task automatic test_irq();
        logic [CH-1:0] ei;
        rst = 1'b1;
        tick();
        alarm[0*AW +: AW] = 8'd1;
        periodic[0] = 1'b0;
        start[0] = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (k == 8) irq_clr[0] = 1'b1;
            if (k == 9) begin periodic[0] = 1'b1; start[0] = 1'b1; end
            if (k == 17) irq_clr[0] = 1'b1;
            tick();
            for (int i = 0; i < CH; i++) ei[i] = m_irq[i];
            n_cmp++;
            if (irq !== ei || pulse !== exp_pulse()) begin
                n_bad++;
                $display("FAIL irq k=%0d: irq=%b pulse=%b required %b %b", k, irq, pulse, ei, exp_pulse());
            end
        end
        n_cmp++;
        if (irq[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set_wins: irq0=%b required 1", irq[0]);
        end
    endtask
`endif

    initial begin
        Clk      = 1'b0;
        rst      = 1'b1;
        start    = '0;
        stop     = '0;
        periodic = '0;
        alarm    = '0;
`ifdef CLOCK_S_IRQ_EN
        irq_clr  = '0;
`endif
        for (int i = 0; i < CH; i++) begin
            m_act[i] = 1'b0; m_next[i] = 0; m_alarm[i] = 0;
            m_per[i] = 1'b0; m_pulse[i] = 1'b0; m_irq[i] = 1'b0;
        end
        #2;
        test_reset();
        test_oneshot();
        test_periodic();
        test_zero_restart();
        test_simultaneous();
        test_mid_reset();
        test_random();
`ifdef CLOCK_S_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
